// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Command sequencer between the UART receiver and transmitter.
//            Parses {rw, addr} / data byte frames, reads or writes a small
//            bank of 8-bit config registers and queues one reply byte per
//            frame for the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int         p_regs    = 4,
    parameter int         p_timeout = 50000,
    parameter logic [7:0] p_ack     = 8'h55,
    parameter logic [7:0] p_nak     = 8'hEE,
    parameter logic [7:0] p_rst_val = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_accept,
    output logic [p_regs*8-1:0]   o_cfg,
    output logic                  o_cfg_wr,
    output logic                  o_overrun
);

    localparam int              c_IW      = (p_regs > 1) ? $clog2(p_regs) : 1;
    localparam int              c_CW      = $clog2(p_timeout + 1);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(p_timeout - 1);
    localparam logic [c_CW-1:0] c_TO_MAX  = c_CW'(p_timeout);
    localparam logic [7:0]      c_NREGS   = 8'(p_regs);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_DATA = 2'd1,
        c_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [6:0]      r_addr;
    logic [c_CW-1:0] r_cnt;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_cfg [p_regs];
    logic            r_cfg_wr;
    logic            r_overrun;

    logic            w_tx_load;
    logic            w_tx_clr;
    logic [7:0]      w_tx_data_nxt;
    logic            w_cfg_we;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_overrun;
    logic            w_rx_addr_ok;
    logic            w_lat_addr_ok;
    logic [c_IW-1:0] w_rx_idx;
    logic [c_IW-1:0] w_lat_idx;
    logic [7:0]      w_rd_data;

    // Range checks come first; the narrow index is only consumed once they pass
    assign w_rx_addr_ok  = ({1'b0, i_rx_data[6:0]} < c_NREGS);
    assign w_lat_addr_ok = ({1'b0, r_addr} < c_NREGS);
    assign w_rx_idx      = i_rx_data[c_IW-1:0];
    assign w_lat_idx     = r_addr[c_IW-1:0];
    assign w_rd_data     = r_cfg[w_rx_idx];

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_load     = 1'b0;
        w_tx_clr      = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_cfg_we      = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_overrun     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data[7]) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = c_DATA;
                    end else begin
                        w_tx_load     = 1'b1;
                        w_tx_data_nxt = w_rx_addr_ok ? w_rd_data : p_nak;
                        w_state_nxt   = c_RESP;
                    end
                end
            end
            c_DATA: begin
                // A byte landing on the timeout cycle still completes the frame
                if (i_rx_valid) begin
                    w_tx_load     = 1'b1;
                    w_tx_data_nxt = w_lat_addr_ok ? p_ack : p_nak;
                    w_cfg_we      = w_lat_addr_ok;
                    w_state_nxt   = c_RESP;
                end else if (r_cnt >= c_TO_LAST) begin
                    w_tx_load     = 1'b1;
                    w_tx_data_nxt = p_nak;
                    w_state_nxt   = c_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            c_RESP: begin
                w_overrun = i_rx_valid;
                if (i_tx_accept && r_tx_valid) begin
                    w_tx_clr    = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched write address and saturating inter-byte timeout counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr <= 7'd0;
            r_cnt  <= '0;
        end else begin
            if (r_state == c_IDLE && i_rx_valid && i_rx_data[7]) begin
                r_addr <= i_rx_data[6:0];
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc && (r_cnt < c_TO_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Reply byte holding register and handshake
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_tx_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_tx_data_nxt;
        end else if (w_tx_clr) begin
            r_tx_valid <= 1'b0;
        end
    end

    // Config register bank plus write / overrun strobes
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < p_regs; k++) begin
                r_cfg[k] <= p_rst_val;
            end
            r_cfg_wr  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_cfg_we) begin
                r_cfg[w_lat_idx] <= i_rx_data;
            end
            r_cfg_wr  <= w_cfg_we;
            r_overrun <= w_overrun;
        end
    end

    generate
        for (genvar g = 0; g < p_regs; g++) begin : g_cfg
            assign o_cfg[8*g +: 8] = r_cfg[g];
        end
    endgenerate

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_cfg_wr   = r_cfg_wr;
    assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Directed, table-driven bench for uart_cmd_ctrl with hand-written
//            sequences for timeout, backpressure/overrun and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int c_REGS    = 4;
    localparam int c_TIMEOUT = 20;

    logic         r_clk = 1'b0;
    logic         r_rst_n;
    logic         r_rx_valid;
    logic [7:0]   r_rx_data;
    logic         r_accept;
    logic         w_tx_valid;
    logic [7:0]   w_tx_data;
    logic [31:0]  w_cfg;
    logic         w_cfg_wr;
    logic         w_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;

    typedef struct {
        logic [7:0]  b0;
        logic        wr;
        logic [7:0]  b1;
        logic [7:0]  tx;
        logic        cfg_wr;
        logic [31:0] cfg;
    } vec_t;

    vec_t vecs [12];

    uart_cmd_ctrl #(
        .p_regs    (c_REGS),
        .p_timeout (c_TIMEOUT),
        .p_ack     (8'h55),
        .p_nak     (8'hEE),
        .p_rst_val (8'h00)
    ) u_dut (
        .i_clk       (r_clk),
        .i_rst       (r_rst_n),
        .i_rx_valid  (r_rx_valid),
        .i_rx_data   (r_rx_data),
        .o_tx_valid  (w_tx_valid),
        .o_tx_data   (w_tx_data),
        .i_tx_accept (r_accept),
        .o_cfg       (w_cfg),
        .o_cfg_wr    (w_cfg_wr),
        .o_overrun   (w_overrun)
    );

    always #5 r_clk = ~r_clk;

    // Count write strobes seen at sample points
    always @(negedge r_clk) begin
        if (w_cfg_wr === 1'b1) n_wr++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: presents one byte for exactly one rising edge
    task automatic pulse(input logic [7:0] b);
        r_rx_valid = 1'b1;
        r_rx_data  = b;
        @(negedge r_clk);
        r_rx_valid = 1'b0;
    endtask

    task automatic accept();
        r_accept = 1'b1;
        @(negedge r_clk);
        r_accept = 1'b0;
    endtask

    initial begin
        int k;
        int wr0;
        logic stable;

        vecs[0]  = '{8'h81, 1'b1, 8'h3C, 8'h55, 1'b1, 32'h00003C00};
        vecs[1]  = '{8'h01, 1'b0, 8'h00, 8'h3C, 1'b0, 32'h00003C00};
        vecs[2]  = '{8'h05, 1'b0, 8'h00, 8'hEE, 1'b0, 32'h00003C00};
        vecs[3]  = '{8'h85, 1'b1, 8'h11, 8'hEE, 1'b0, 32'h00003C00};
        vecs[4]  = '{8'h80, 1'b1, 8'hA5, 8'h55, 1'b1, 32'h00003CA5};
        vecs[5]  = '{8'h83, 1'b1, 8'h7E, 8'h55, 1'b1, 32'h7E003CA5};
        vecs[6]  = '{8'h03, 1'b0, 8'h00, 8'h7E, 1'b0, 32'h7E003CA5};
        vecs[7]  = '{8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 32'h7E003CA5};
        vecs[8]  = '{8'h04, 1'b0, 8'h00, 8'hEE, 1'b0, 32'h7E003CA5};
        vecs[9]  = '{8'hFF, 1'b1, 8'h22, 8'hEE, 1'b0, 32'h7E003CA5};
        vecs[10] = '{8'h82, 1'b1, 8'hFF, 8'h55, 1'b1, 32'h7EFF3CA5};
        vecs[11] = '{8'h02, 1'b0, 8'h00, 8'hFF, 1'b0, 32'h7EFF3CA5};

        r_rst_n    = 1'b0;
        r_rx_valid = 1'b0;
        r_rx_data  = 8'h00;
        r_accept   = 1'b0;

        // Reset state
        repeat (2) @(negedge r_clk);
        chk("rst_tx_valid", 32'(w_tx_valid), 32'h0);
        chk("rst_tx_data",  32'(w_tx_data),  32'h0);
        chk("rst_cfg",      w_cfg,           32'h0);
        chk("rst_cfg_wr",   32'(w_cfg_wr),   32'h0);
        chk("rst_overrun",  32'(w_overrun),  32'h0);
        r_rst_n = 1'b1;
        @(negedge r_clk);

        // Table-driven frames
        for (int i = 0; i < 12; i++) begin
            pulse(vecs[i].b0);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wait_data", i), 32'(w_tx_valid), 32'h0);
                pulse(vecs[i].b1);
            end
            chk($sformatf("v%0d_tx_valid", i), 32'(w_tx_valid), 32'h1);
            chk($sformatf("v%0d_tx_data", i),  32'(w_tx_data),  32'(vecs[i].tx));
            chk($sformatf("v%0d_cfg_wr", i),   32'(w_cfg_wr),   32'(vecs[i].cfg_wr));
            chk($sformatf("v%0d_cfg", i),      w_cfg,           vecs[i].cfg);
            accept();
            chk($sformatf("v%0d_tx_done", i),  32'(w_tx_valid), 32'h0);
            chk($sformatf("v%0d_wr_end", i),   32'(w_cfg_wr),   32'h0);
        end

        // Timeout on a write with no data byte
        wr0 = n_wr;
        pulse(8'h82);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge r_clk);
            if (w_tx_valid) begin
                k = i;
                break;
            end
        end
        chk("to_latency",  32'(k),          32'(c_TIMEOUT));
        chk("to_tx_data",  32'(w_tx_data),  32'hEE);
        chk("to_cfg",      w_cfg,           32'h7EFF3CA5);
        chk("to_no_wr",    32'(n_wr - wr0), 32'h0);
        accept();
        pulse(8'h02);
        chk("to_idle_read", 32'(w_tx_data), 32'hFF);
        accept();

        // Data byte on the very cycle the timeout would fire wins
        pulse(8'h82);
        repeat (c_TIMEOUT - 1) @(negedge r_clk);
        chk("edge_not_yet", 32'(w_tx_valid), 32'h0);
        pulse(8'h44);
        chk("edge_tx_valid", 32'(w_tx_valid), 32'h1);
        chk("edge_tx_data",  32'(w_tx_data),  32'h55);
        chk("edge_cfg_wr",   32'(w_cfg_wr),   32'h1);
        chk("edge_cfg",      w_cfg,           32'h7E443CA5);
        accept();

        // Backpressure then overrun
        pulse(8'h00);
        stable = 1'b1;
        repeat (100) begin
            @(negedge r_clk);
            if (w_tx_valid !== 1'b1 || w_tx_data !== 8'hA5) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'h1);
        pulse(8'h81);
        chk("ovr_pulse",    32'(w_overrun),  32'h1);
        chk("ovr_tx_valid", 32'(w_tx_valid), 32'h1);
        chk("ovr_tx_data",  32'(w_tx_data),  32'hA5);
        @(negedge r_clk);
        chk("ovr_one_cycle", 32'(w_overrun), 32'h0);
        // Byte in the same cycle as accept is still dropped
        r_accept = 1'b1;
        pulse(8'h81);
        r_accept = 1'b0;
        chk("ovr_acc_pulse", 32'(w_overrun),  32'h1);
        chk("ovr_acc_done",  32'(w_tx_valid), 32'h0);
        @(negedge r_clk);
        // If 0x81 had been taken, 0x01 would be write data and get an ACK
        pulse(8'h01);
        chk("ovr_ignored", 32'(w_tx_data), 32'h3C);
        chk("ovr_cfg",     w_cfg,          32'h7E443CA5);
        accept();

        // Async reset mid-DATA
        pulse(8'h83);
        #2 r_rst_n = 1'b0;
        #1;
        chk("rstd_tx_valid", 32'(w_tx_valid), 32'h0);
        chk("rstd_cfg",      w_cfg,           32'h0);
        @(negedge r_clk);
        r_rst_n = 1'b1;
        repeat (3) @(negedge r_clk);
        chk("rstd_no_reply", 32'(w_tx_valid), 32'h0);
        pulse(8'h03);
        chk("rstd_read_valid", 32'(w_tx_valid), 32'h1);
        chk("rstd_read_data",  32'(w_tx_data),  32'h00);
        chk("rstd_no_wr",      32'(w_cfg_wr),   32'h0);

        // Async reset mid-RESP drops o_tx_valid before any clock edge
        #2 r_rst_n = 1'b0;
        #1;
        chk("rstr_tx_valid", 32'(w_tx_valid), 32'h0);
        @(negedge r_clk);
        r_rst_n = 1'b1;
        @(negedge r_clk);
        chk("rstr_idle", 32'(w_tx_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
